// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at the
// accepting edge and held in temp_hi/temp_lo until the busy countdown expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MD_Control,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [31:0]   temp_hi, temp_lo;
  logic          upd;

  logic accept, mt_lo, mt_hi;
  assign accept = (state == IDLE) && start && (MD_Control[3:2] == 2'b00);
  assign mt_lo  = (state == IDLE) && start && (MD_Control == 4'd4);
  assign mt_hi  = (state == IDLE) && start && (MD_Control == 4'd5);

  // Signed divide is done on magnitudes; 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  logic [63:0] smul, umul, res;
  logic [31:0] dvs, uq, ur, abs_a, abs_b, abs_bs, sq_m, sr_m, sq, sr;
  always_comb begin
    smul   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    umul   = {32'd0, A} * {32'd0, B};
    dvs    = (B == 32'd0) ? 32'd1 : B;
    uq     = A / dvs;
    ur     = A % dvs;
    abs_a  = A[31] ? -A : A;
    abs_b  = B[31] ? -B : B;
    abs_bs = (abs_b == 32'd0) ? 32'd1 : abs_b;
    sq_m   = abs_a / abs_bs;
    sr_m   = abs_a % abs_bs;
    sq     = (A[31] ^ B[31]) ? -sq_m : sq_m;
    sr     = A[31] ? -sr_m : sr_m;
    case (MD_Control[1:0])
      2'd0:    res = smul;
      2'd1:    res = umul;
      2'd2:    res = {sr, sq};
      default: res = {ur, uq};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (cnt == CW'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    case (MD_Control)
      4'd7:    MDOut = HI;
      4'd6:    MDOut = LO;
      default: MDOut = 32'd0;
    endcase
  end

  // Divide by zero still runs the full countdown but skips the HI/LO commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      upd     <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (accept) begin
      temp_hi <= res[63:32];
      temp_lo <= res[31:0];
      cnt     <= MD_Control[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      upd     <= !MD_Control[1] || (B != 32'd0);
    end else if (state == RUN) begin
      if (cnt == CW'(1)) begin
        if (upd) begin
          HI <= temp_hi;
          LO <= temp_lo;
        end
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (mt_lo) begin
      LO <= A;
    end else if (mt_hi) begin
      HI <= A;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: completions are queued at issue and checked
// by a monitor when busy falls; mf reads check the bench's own HI/LO model.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  code;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, mdout;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(rst_n), .start(start), .MD_Control(code),
    .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo), .MDOut(mdout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_hi = 0, model_lo = 0;
  int          total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the arithmetic rules.
  function automatic logic [63:0] ref_res(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    longint     p;
    int         q, r;
    logic [63:0] u;
    case (c)
      4'd0: begin p = longint'($signed(x)) * longint'($signed(y)); return p; end
      4'd1: begin u = {32'd0, x} * {32'd0, y}; return u; end
      4'd2: begin
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = int'(x) / int'(y);
        r = int'(x) % int'(y);
        return {r, q};
      end
      default: return {x % y, x / y};
    endcase
  endfunction

  // Monitor: HI/LO must hold pre-op values while busy; the fall of busy is a completion.
  int   bcnt = 0;
  logic bprev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bcnt  = 0;
      bprev = 1'b0;
    end else begin
      if (busy) begin
        bcnt++;
        chk("hold_hi", hi, model_hi);
        chk("hold_lo", lo, model_lo);
      end else if (bprev) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: busy fell with %0d expected completions queued", 0);
        end else begin
          e = sb.pop_front();
          chk("busy_len", 32'(bcnt), 32'(e.cyc));
          chk("done_hi", hi, e.hi);
          chk("done_lo", lo, e.lo);
          model_hi = e.hi;
          model_lo = e.lo;
        end
        bcnt = 0;
      end
      bprev = busy;
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input bit expect_run);
    exp_t e;
    logic [63:0] r;
    @(posedge clk); #1;
    start = 1'b1; code = c; a = x; b = y;
    if (expect_run && c < 4) begin
      if (c >= 2 && y == 32'd0) begin
        e.hi = model_hi; e.lo = model_lo;
      end else begin
        r = ref_res(c, x, y);
        e.hi = r[63:32]; e.lo = r[31:0];
      end
      e.cyc = (c >= 2) ? DC : MC;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; code = 4'hF;
    if (expect_run && c == 4'd4) model_lo = x;
    if (expect_run && c == 4'd5) model_hi = x;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL timeout: busy still %b after %0d cycles", busy, n);
    end
    @(negedge clk); #1;
  endtask

  task automatic do_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    issue(c, x, y, 1'b1);
    wait_idle();
  endtask

  task automatic mf_check();
    start = 1'b0;
    code = 4'd7; #1 chk("mfhi", mdout, model_hi);
    code = 4'd6; #1 chk("mflo", mdout, model_lo);
    code = 4'd4; #1 chk("mf_other", mdout, 32'd0);
    code = 4'hF; #1;
  endtask

  initial begin
    int pick;
    logic [3:0]  c;
    logic [31:0] x, y;
    rst_n = 1'b0; start = 1'b0; code = 4'hF; a = 0; b = 0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mdout", mdout, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(4'd0, 32'hFFFF_FFFF, 32'd2);
    chk("t1_hi", hi, 32'hFFFF_FFFF);
    chk("t1_lo", lo, 32'hFFFF_FFFE);
    mf_check();
    do_op(4'd1, 32'hFFFF_FFFF, 32'd2);
    chk("t2_hi", hi, 32'h0000_0001);
    chk("t2_lo", lo, 32'hFFFF_FFFE);
    do_op(4'd2, 32'hFFFF_FFF9, 32'd2);
    chk("t3_hi", hi, 32'hFFFF_FFFF);
    chk("t3_lo", lo, 32'hFFFF_FFFD);
    do_op(4'd5, 32'h11, 0);
    do_op(4'd4, 32'h22, 0);
    do_op(4'd3, 32'd7, 32'd0);
    chk("t4_div0_hi", hi, 32'h11);
    chk("t4_div0_lo", lo, 32'h22);
    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("t4_ovf_hi", hi, 32'd0);
    chk("t4_ovf_lo", lo, 32'h8000_0000);
    do_op(4'd5, 32'h1234_5678, 0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_hi", hi, 32'h1234_5678);
    mf_check();

    // Starts while a div is running must be ignored.
    issue(4'd2, 32'd100, 32'd7, 1'b1);
    issue(4'd0, 32'd3, 32'd3, 1'b0);
    issue(4'd5, 32'hDEAD_BEEF, 0, 1'b0);
    wait_idle();
    chk("ign_hi", hi, 32'd2);
    chk("ign_lo", lo, 32'd14);

    // Asynchronous reset in the middle of a div.
    issue(4'd2, 32'd1000, 32'd3, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    model_hi = 0; model_lo = 0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("arst_nolate_hi", hi, 32'd0);
    chk("arst_nolate_lo", lo, 32'd0);
    do_op(4'd0, 32'd6, 32'hFFFF_FFFD);
    chk("arst_next_lo", lo, 32'hFFFF_FFEE);

    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 8)       c = 4'(pick);
      else if (pick == 8) c = 4'hF;
      else                c = 4'(8 + $urandom_range(0, 6));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = 32'(int'($urandom_range(1, 20)));
        default: ;
      endcase
      do_op(c, x, y);
      if (c == 4'd6 || c == 4'd7 || $urandom_range(0, 3) == 0) mf_check();
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multi-cycle multiply/divide responder in the E stage of the P6 pipeline. It consumes the 4-bit MD_Control code produced by the decoder, together with rs/rt operands, and owns the HI/LO registers. It raises busy while an operation is in flight, and returns HI or LO for mfhi/mflo. Hazard logic stalls D when a D-stage md/mt/mf instruction meets (start | busy).

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (>=1)
DIV_CYCLES, 10, busy duration for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state
start  input  1  E-stage instruction valid; qualifies MD_Control
MD_Control  input  4  operation code; values fixed in macro.v (see Behaviour)
A  input  32  forwarded rs value
B  input  32  forwarded rt value
busy  output  1  operation in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MDOut  output  32  mf result to E/M pipeline register

Behaviour:
- MD_Control encoding: mult=0, multu=1, div=2, divu=3, mtlo=4, mthi=5, mflo=6, mfhi=7, none=4'b1111. Codes 8..14 are treated as none.
- Reset (reset==0, asynchronous): HI=0, LO=0, busy=0, state=IDLE, counter=0, temp result=0. Reset mid-operation aborts the operation. No HI/LO update occurs afterwards.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - Counter is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1) bits.
- Accept (IDLE, start=1, code 0..3), at the accepting edge:
  - Compute the 64-bit result from A and B. Latch the result into temp_hi/temp_lo.
  - Load the counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu). Go to RUN.
- RUN, at each edge:
  - If counter != 1: counter-1.
  - If counter == 1: HI<=temp_hi, LO<=temp_lo, go to IDLE.
  - busy is therefore high for exactly N cycles after the accepting edge. The new HI/LO are visible in the same cycle busy falls.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B).
  - multu: the same product, unsigned.
  - div: LO = A/B truncated toward zero; HI = remainder with the sign of A.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / -1 (div): LO=0x80000000, HI=0.
  - Divide by zero (div/divu): the operation runs the full DIV_CYCLES with busy high, then leaves HI/LO unchanged.
- mthi/mtlo (IDLE, start=1): HI<=A or LO<=A at the next edge. busy stays 0.
- mfhi/mflo: MDOut is combinational, = HI or LO, whenever MD_Control is 7 or 6, regardless of start. For all other codes MDOut = 0.
- Start while busy (any code 0..5): ignored. There is no state change, and HI/LO keep their in-flight values. Hazard logic guarantees this never happens in a correct pipeline. The bench checks that it is harmless.
- MD_Control of none, or start=0: no state change.
- An mf read while busy returns the pre-operation value. Stall logic prevents this architecturally.

Test Plan:
1. mult with A=0xFFFFFFFF, B=2 -> busy=1 for 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MDOut via mfhi = 0xFFFFFFFF.
2. multu with A=0xFFFFFFFF, B=2 -> after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE. HI/LO hold their old values during busy.
3. div with A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
4. divu with A=7, B=0, where HI=0x11 and LO=0x22 beforehand -> busy for 10 cycles, then HI=0x11 and LO=0x22 unchanged. Repeat with div, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
5. mthi with A=0x12345678, then mflo next cycle -> HI=0x12345678 one edge later, busy never asserted. MDOut equals LO. Also: a start(mult) issued at cycle 2 of a running div is ignored, and the div result lands at cycle 10.
6. Drop reset to 0 asynchronously in cycle 4 of a div and release it -> busy=0, HI=0, LO=0 immediately. No later update; the next mult completes normally.
